// File: rtl/prog_loader.sv
// Framed byte-stream program loader: assembles big-endian words, writes them to
// program memory with a pclk strobe, checks an XOR checksum, then pulses cpu_rst.
module prog_loader #(
  parameter logic [15:0] PROG_START = 16'h000F,
  parameter logic [15:0] MAX_WORDS  = 16'hFFF0,
  parameter logic [23:0] TIMEOUT    = 24'd1_000_000,
  parameter int unsigned RST_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        pgm,
  output logic        pclk,
  output logic [15:0] mem_addr,
  output logic [15:0] mem_data,
  output logic        mem_we,
  output logic        cpu_rst,
  output logic        done,
  output logic        err
);

  localparam logic [7:0] SYNC     = 8'hA5;
  localparam logic [3:0] RST_LAST = 4'(RST_CYCLES - 1);

  typedef enum logic [3:0] {
    IDLE, LEN_H, LEN_L, DATA_H, DATA_L, WRITE, STROBE, CHK, RUN, ERR
  } state_t;

  state_t      state;
  logic        live;
  logic [7:0]  len_h;
  logic [15:0] len;
  logic [15:0] idx;
  logic [7:0]  hi;
  logic [7:0]  acc;
  logic [23:0] tmo;
  logic [3:0]  rst_cnt;
  logic        xfer;
  logic        in_frame;
  logic [15:0] len_in;

  // live keeps rx_ready low until the first clock after reset release
  assign rx_ready = live && (state inside {IDLE, LEN_H, LEN_L, DATA_H, DATA_L, CHK, ERR});
  assign xfer     = rx_valid && rx_ready;
  assign in_frame = state inside {LEN_H, LEN_L, DATA_H, DATA_L, CHK};
  assign len_in   = {len_h, rx_data};

  assign pgm     = !(state inside {IDLE, RUN});
  assign pclk    = (state == STROBE);
  assign mem_we  = (state inside {WRITE, STROBE});
  assign cpu_rst = (state == RUN);
  assign err     = (state == ERR);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      live     <= 1'b0;
      len_h    <= 8'h00;
      len      <= 16'h0000;
      idx      <= 16'h0000;
      hi       <= 8'h00;
      acc      <= 8'h00;
      tmo      <= 24'd0;
      rst_cnt  <= 4'd0;
      mem_addr <= 16'h0000;
      mem_data <= 16'h0000;
      done     <= 1'b0;
    end else begin
      live <= 1'b1;
      done <= 1'b0;
      case (state)
        IDLE, ERR: begin
          if (xfer && rx_data == SYNC) begin
            state <= LEN_H;
            idx   <= 16'h0000;
            acc   <= 8'h00;
          end
        end
        LEN_H: begin
          if (xfer) begin
            len_h <= rx_data;
            state <= LEN_L;
          end
        end
        LEN_L: begin
          if (xfer) begin
            len <= len_in;
            if (len_in == 16'h0000 || len_in > MAX_WORDS) state <= ERR;
            else state <= DATA_H;
          end
        end
        DATA_H: begin
          if (xfer) begin
            hi    <= rx_data;
            acc   <= acc ^ rx_data;
            state <= DATA_L;
          end
        end
        DATA_L: begin
          if (xfer) begin
            mem_addr <= PROG_START + idx;
            mem_data <= {hi, rx_data};
            acc      <= acc ^ rx_data;
            state    <= WRITE;
          end
        end
        WRITE: state <= STROBE;
        STROBE: begin
          idx   <= idx + 16'd1;
          state <= (idx + 16'd1 == len) ? CHK : DATA_H;
        end
        CHK: begin
          if (xfer) begin
            rst_cnt <= 4'd0;
            state   <= (rx_data == acc) ? RUN : ERR;
          end
        end
        RUN: begin
          if (rst_cnt == RST_LAST) begin
            state <= IDLE;
            done  <= 1'b1;
          end else begin
            rst_cnt <= rst_cnt + 4'd1;
          end
        end
        default: state <= IDLE;
      endcase

      // Inter-byte watchdog; overrides the case above when it expires
      if (in_frame && !xfer) begin
        if (tmo == TIMEOUT - 24'd1) begin
          tmo   <= 24'd0;
          state <= ERR;
        end else begin
          tmo <= tmo + 24'd1;
        end
      end else begin
        tmo <= 24'd0;
      end
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
// Self-checking bench for prog_loader: scenario tasks plus a write scoreboard
// filled when words are sent and drained on each memory strobe.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready, pgm, pclk, mem_we, cpu_rst, done, err;
  logic [15:0] mem_addr, mem_data;

  prog_loader #(.TIMEOUT(24'd16)) dut (
    .clk(clk), .rst_n(rst_n), .rx_data(rx_data), .rx_valid(rx_valid),
    .rx_ready(rx_ready), .pgm(pgm), .pclk(pclk), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_we(mem_we), .cpu_rst(cpu_rst), .done(done), .err(err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  logic [31:0] exp_q[$];
  int we_cycles = 0, pclk_pulses = 0, rst_cycles = 0, done_pulses = 0;
  logic pclk_d = 1'b0;

  // Monitor: activity counters and scoreboard drain on the strobe cycle
  always @(negedge clk) begin
    logic [31:0] exp_w;
    if (pclk && !pclk_d) pclk_pulses = pclk_pulses + 1;
    pclk_d = pclk;
    if (mem_we) we_cycles = we_cycles + 1;
    if (cpu_rst) rst_cycles = rst_cycles + 1;
    if (done) done_pulses = done_pulses + 1;
    if (mem_we && pclk) begin
      tests++;
      if (exp_q.size() == 0) begin
        fails++;
        $display("FAIL write_unexpected got addr=%h data=%h want no write", mem_addr, mem_data);
      end else begin
        exp_w = exp_q.pop_front();
        if ({mem_addr, mem_data} !== exp_w) begin
          fails++;
          $display("FAIL write got addr=%h data=%h want addr=%h data=%h",
                   mem_addr, mem_data, exp_w[31:16], exp_w[15:0]);
        end else begin
          $display("[TB] write addr=%h data=%h ok", mem_addr, mem_data);
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b);
    bit ok = 1'b0;
    @(negedge clk);
    rx_data  = b;
    rx_valid = 1'b1;
    for (int i = 0; i < 64; i++) begin
      if (rx_ready) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (ok) @(posedge clk);
    #1 rx_valid = 1'b0;
    if (!ok) begin
      tests++;
      fails++;
      $display("FAIL send_byte got rx_ready=0 for 64 cycles want accept of %h", b);
    end
  endtask

  task automatic send_word(input logic [15:0] idx, input logic [15:0] w);
    logic [15:0] addr = 16'h000F + idx;
    exp_q.push_back({addr, w});
    send_byte(w[15:8]);
    send_byte(w[7:0]);
  endtask

  task automatic wait_done(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (done) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #3;
    tests++;
    if ({pgm, pclk, mem_we, cpu_rst, done, err, rx_ready, mem_addr, mem_data} !== 39'd0) begin
      fails++;
      $display("FAIL reset_values got %b want all zero",
               {pgm, pclk, mem_we, cpu_rst, done, err, rx_ready, mem_addr, mem_data});
    end
    repeat (2) @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    #1;
    tests++;
    if (rx_ready !== 1'b0) begin
      fails++; $display("FAIL reset_ready_before_clk got %b want 0", rx_ready);
    end
    @(posedge clk); #1;
    tests++;
    if (rx_ready !== 1'b1) begin
      fails++; $display("FAIL reset_ready_after_clk got %b want 1", rx_ready);
    end
    $display("[TB] reset checked");
  endtask

  task automatic test_good_frame();
    int we0 = we_cycles, pc0 = pclk_pulses, rc0 = rst_cycles, dn0 = done_pulses;
    bit ok;
    send_byte(8'hA5);
    @(negedge clk);
    tests++;
    if ({pgm, err} !== 2'b10) begin
      fails++; $display("FAIL good_pgm_after_sync got pgm,err=%b want 10", {pgm, err});
    end
    send_byte(8'h00); send_byte(8'h02);
    send_word(16'd0, 16'h1234);
    send_word(16'd1, 16'hABCD);
    send_byte(8'h40);
    @(negedge clk);
    tests++;
    if ({cpu_rst, pgm} !== 2'b10) begin
      fails++; $display("FAIL good_run_entry got cpu_rst,pgm=%b want 10", {cpu_rst, pgm});
    end
    wait_done(ok);
    tests++;
    if (!ok) begin
      fails++; $display("FAIL good_done_timeout got no done want done within 32 cycles");
    end
    @(negedge clk);
    tests++;
    if (done !== 1'b0) begin
      fails++; $display("FAIL good_done_width got done=%b want 0", done);
    end
    tests++;
    if (we_cycles - we0 != 4 || pclk_pulses - pc0 != 2) begin
      fails++; $display("FAIL good_write_cycles got we=%0d pclk=%0d want we=4 pclk=2",
                        we_cycles - we0, pclk_pulses - pc0);
    end
    tests++;
    if (rst_cycles - rc0 != 4 || done_pulses - dn0 != 1) begin
      fails++; $display("FAIL good_rst_pulse got cpu_rst=%0d done=%0d want cpu_rst=4 done=1",
                        rst_cycles - rc0, done_pulses - dn0);
    end
    tests++;
    if ({err, pgm} !== 2'b00 || exp_q.size() != 0) begin
      fails++; $display("FAIL good_final got err,pgm=%b pending=%0d want 00 pending=0",
                        {err, pgm}, exp_q.size());
    end
    $display("[TB] good frame done");
  endtask

  task automatic test_noise();
    logic [7:0] noise [3] = '{8'h00, 8'hFF, 8'h5A};
    int dn0 = done_pulses;
    bit ok;
    for (int i = 0; i < 3; i++) begin
      send_byte(noise[i]);
      @(negedge clk);
      tests++;
      if ({pgm, err} !== 2'b00) begin
        fails++; $display("FAIL noise_dropped got pgm,err=%b want 00 after byte %h", {pgm, err}, noise[i]);
      end
    end
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
    send_word(16'd0, 16'hBEEF);
    send_byte(8'h51);
    wait_done(ok);
    @(negedge clk);
    tests++;
    if (!ok || done_pulses - dn0 != 1 || exp_q.size() != 0) begin
      fails++; $display("FAIL noise_then_load got ok=%0d done=%0d pending=%0d want 1 1 0",
                        ok, done_pulses - dn0, exp_q.size());
    end
    $display("[TB] noise then load done");
  endtask

  task automatic test_bad_chk();
    int rc0 = rst_cycles;
    bit ok;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
    send_word(16'd0, 16'h1234);
    send_word(16'd1, 16'hABCD);
    send_byte(8'h41);
    @(negedge clk);
    tests++;
    if ({err, pgm, rx_ready, cpu_rst} !== 4'b1110) begin
      fails++; $display("FAIL badchk_err got err,pgm,ready,cpu_rst=%b want 1110",
                        {err, pgm, rx_ready, cpu_rst});
    end
    repeat (8) @(negedge clk);
    tests++;
    if (rst_cycles != rc0 || err !== 1'b1) begin
      fails++; $display("FAIL badchk_sticky got cpu_rst_cycles=%0d err=%b want 0 1",
                        rst_cycles - rc0, err);
    end
    send_byte(8'hA5);
    @(negedge clk);
    tests++;
    if ({err, pgm} !== 2'b01) begin
      fails++; $display("FAIL badchk_clear got err,pgm=%b want 01", {err, pgm});
    end
    send_byte(8'h00); send_byte(8'h01);
    send_word(16'd0, 16'h5678);
    send_byte(8'h2E);
    wait_done(ok);
    @(negedge clk);
    tests++;
    if (!ok || err !== 1'b0 || rst_cycles - rc0 != 4 || exp_q.size() != 0) begin
      fails++; $display("FAIL badchk_recover got ok=%0d err=%b cpu_rst=%0d pending=%0d want 1 0 4 0",
                        ok, err, rst_cycles - rc0, exp_q.size());
    end
    $display("[TB] bad checksum then recovery done");
  endtask

  task automatic test_bad_len();
    int we0 = we_cycles;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h00);
    @(negedge clk);
    tests++;
    if (err !== 1'b1) begin
      fails++; $display("FAIL len_zero got err=%b want 1", err);
    end
    send_byte(8'hA5);
    @(negedge clk);
    tests++;
    if (err !== 1'b0) begin
      fails++; $display("FAIL len_resync got err=%b want 0", err);
    end
    send_byte(8'hFF); send_byte(8'hF1);
    @(negedge clk);
    tests++;
    if (err !== 1'b1 || we_cycles != we0) begin
      fails++; $display("FAIL len_fff1 got err=%b we_cycles=%0d want 1 0", err, we_cycles - we0);
    end
    $display("[TB] bad length done");
  endtask

  task automatic test_timeout();
    int we0 = we_cycles;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
    send_byte(8'h12);
    repeat (15) @(posedge clk);
    #1;
    tests++;
    if ({err, pgm} !== 2'b01) begin
      fails++; $display("FAIL timeout_early got err,pgm=%b want 01 after 15 idle cycles", {err, pgm});
    end
    @(posedge clk); #1;
    tests++;
    if ({err, pgm} !== 2'b11 || we_cycles != we0) begin
      fails++; $display("FAIL timeout_expire got err,pgm=%b we=%0d want 11 0", {err, pgm}, we_cycles - we0);
    end
    $display("[TB] timeout done");
  endtask

  task automatic test_midframe_reset();
    bit ok;
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h02);
    send_word(16'd0, 16'h1122);
    send_byte(8'h33);
    @(negedge clk);
    rx_data  = 8'h44;
    rx_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    tests++;
    if ({pgm, pclk, mem_we, cpu_rst, done, err, rx_ready, mem_addr, mem_data} !== 39'd0) begin
      fails++; $display("FAIL midreset_values got %b want all zero",
                        {pgm, pclk, mem_we, cpu_rst, done, err, rx_ready, mem_addr, mem_data});
    end
    tests++;
    if (exp_q.size() != 0) begin
      fails++; $display("FAIL midreset_pending got %0d want 0", exp_q.size());
    end
    @(negedge clk) rst_n = 1'b1;
    #1;
    tests++;
    if (rx_ready !== 1'b0) begin
      fails++; $display("FAIL midreset_ready_before got %b want 0", rx_ready);
    end
    @(posedge clk); #1;
    rx_valid = 1'b0;
    tests++;
    if (rx_ready !== 1'b1 || pgm !== 1'b0) begin
      fails++; $display("FAIL midreset_ready_after got ready,pgm=%b want 10", {rx_ready, pgm});
    end
    send_byte(8'hA5); send_byte(8'h00); send_byte(8'h01);
    send_word(16'd0, 16'hCAFE);
    send_byte(8'h34);
    wait_done(ok);
    @(negedge clk);
    tests++;
    if (!ok || err !== 1'b0 || exp_q.size() != 0) begin
      fails++; $display("FAIL midreset_reload got ok=%0d err=%b pending=%0d want 1 0 0",
                        ok, err, exp_q.size());
    end
    $display("[TB] mid-frame reset done");
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_noise();
    test_bad_chk();
    test_bad_len();
    test_timeout();
    test_midframe_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got no finish want finish before 200000");
    $fatal(1, "watchdog expired");
  end

endmodule
